// File: rtl/frame_pkg.sv
// Shared types and constants for the receive-side frame assembler.
// Wire format: DST MAC, SRC MAC, LEN byte, then LEN payload bytes.
package frame_pkg;

    localparam int MAC_BYTES    = 12;
    localparam int LEN_W        = 8;
    localparam int DROP_CNT_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DST,
        ST_SRC,
        ST_LEN,
        ST_PAYLOAD,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/idle_timer.sv
// Counts idle cycles while enabled; expire fires on the last allowed cycle.
// A clear in the same cycle suppresses expiry and restarts the count.
module idle_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expire = enable && !clear && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || !enable || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frame_assembler.sv
// Parses a received byte stream into header fields and a buffered payload,
// then streams the payload out over valid/ready; bad or stalled frames drop.
module frame_assembler #(
    parameter int DATA_LEN    = 8,
    parameter int MAC_BYTES   = 12,
    parameter int MAX_PAYLOAD = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rec_complete,
    input  logic [DATA_LEN-1:0]    din,
    output logic [MAC_BYTES*8-1:0] frm_dst,
    output logic [MAC_BYTES*8-1:0] frm_src,
    output logic [7:0]             frm_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LEN-1:0]    out_data,
    output logic                   out_last,
    output logic                   err_drop,
    output logic [7:0]             drop_count
);

    import frame_pkg::*;

    localparam int MW  = MAC_BYTES * 8;
    localparam int BCW = $clog2(MAC_BYTES);
    localparam int PW  = $clog2(MAX_PAYLOAD);

    state_t              state;
    logic [BCW-1:0]      byte_cnt;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [DATA_LEN-1:0] pay_buf [MAX_PAYLOAD];

    logic len_bad;
    logic last_wr;
    logic mac_done;
    logic timer_en;
    logic expire;
    logic drop_ev;

    assign len_bad  = (din == '0) || (din > LEN_W'(MAX_PAYLOAD));
    assign last_wr  = LEN_W'(wr_ptr) == frm_len - 1'b1;
    assign mac_done = byte_cnt == BCW'(MAC_BYTES - 1);
    assign timer_en = (state == ST_DST) || (state == ST_SRC) ||
                      (state == ST_LEN) || (state == ST_PAYLOAD);

    assign drop_ev = expire ||
                     (rec_complete && state == ST_HOLD) ||
                     (rec_complete && state == ST_LEN && len_bad);

    idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clear (rec_complete),
        .enable(timer_en),
        .expire(expire)
    );

    // Payload storage is plain data: no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_PAYLOAD && rec_complete) begin
            pay_buf[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frm_dst    <= '0;
            frm_src    <= '0;
            frm_len    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            err_drop   <= 1'b0;
            drop_count <= '0;
        end else begin
            err_drop <= drop_ev;
            if (drop_ev && drop_count != LEN_W'(DROP_CNT_MAX)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (expire) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (rec_complete) begin
                            frm_dst  <= {frm_dst[MW-DATA_LEN-1:0], din};
                            byte_cnt <= BCW'(1);
                            state    <= ST_DST;
                        end
                    end
                    ST_DST: begin
                        if (rec_complete) begin
                            frm_dst <= {frm_dst[MW-DATA_LEN-1:0], din};
                            if (mac_done) begin
                                byte_cnt <= '0;
                                state    <= ST_SRC;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    ST_SRC: begin
                        if (rec_complete) begin
                            frm_src <= {frm_src[MW-DATA_LEN-1:0], din};
                            if (mac_done) begin
                                byte_cnt <= '0;
                                state    <= ST_LEN;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    ST_LEN: begin
                        if (rec_complete) begin
                            frm_len <= din;
                            wr_ptr  <= '0;
                            state   <= len_bad ? ST_IDLE : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rec_complete) begin
                            if (last_wr) begin
                                rd_ptr <= '0;
                                state  <= ST_HOLD;
                            end else begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        // First HOLD cycle only loads beat 0 from the buffer.
                        if (!out_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= pay_buf[rd_ptr];
                            out_last  <= frm_len == LEN_W'(1);
                        end else if (out_ready) begin
                            if (out_last) begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                state     <= ST_IDLE;
                            end else begin
                                rd_ptr   <= rd_ptr + 1'b1;
                                out_data <= pay_buf[rd_ptr + 1'b1];
                                out_last <= LEN_W'(rd_ptr) + LEN_W'(2) == frm_len;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_frame_assembler;

    localparam int MB   = 12;
    localparam int MAXP = 16;
    localparam int TMO  = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          rec_complete;
    logic [7:0]    din;
    logic [95:0]   frm_dst;
    logic [95:0]   frm_src;
    logic [7:0]    frm_len;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic          err_drop;
    logic [7:0]    drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_assembler #(
        .DATA_LEN   (8),
        .MAC_BYTES  (MB),
        .MAX_PAYLOAD(MAXP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rec_complete(rec_complete),
        .din         (din),
        .frm_dst     (frm_dst),
        .frm_src     (frm_src),
        .frm_len     (frm_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err_drop    (err_drop),
        .drop_count  (drop_count)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: frame bytes collected in a queue, payload replayed
    // from a queue, idle gap counted in whole clocks.
    logic [7:0]  rx[$];
    logic [7:0]  pay[$];
    bit          busy;
    bit          hold;
    int          idle;
    logic        exp_valid;
    logic        exp_drop;
    logic [7:0]  exp_cnt;
    logic [7:0]  exp_len;
    logic [95:0] exp_dst;
    logic [95:0] exp_src;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx.delete();
            pay.delete();
            busy      = 0;
            hold      = 0;
            idle      = 0;
            exp_valid = 0;
            exp_drop  = 0;
            exp_cnt   = 0;
            exp_len   = 0;
            exp_dst   = 0;
            exp_src   = 0;
        end else begin
            bit drop;
            drop = 0;
            if (hold) begin
                if (rec_complete) drop = 1;
                if (!exp_valid) begin
                    exp_valid = 1;
                end else if (out_ready) begin
                    void'(pay.pop_front());
                    if (pay.size() == 0) begin
                        hold      = 0;
                        exp_valid = 0;
                    end
                end
            end else if (rec_complete) begin
                rx.push_back(din);
                idle = 0;
                busy = 1;
                if (rx.size() == 2*MB+1 && (din == 0 || din > MAXP)) begin
                    drop = 1;
                    rx.delete();
                    busy = 0;
                end else if (rx.size() > 2*MB+1 &&
                             rx.size() == 2*MB+1+int'(rx[2*MB])) begin
                    exp_dst = 0;
                    exp_src = 0;
                    for (int i = 0; i < MB; i++) begin
                        exp_dst = {exp_dst[87:0], rx[i]};
                        exp_src = {exp_src[87:0], rx[MB+i]};
                    end
                    exp_len = rx[2*MB];
                    pay     = rx[2*MB+1:$];
                    hold    = 1;
                    busy    = 0;
                    rx.delete();
                end
            end else if (busy) begin
                idle++;
                if (idle == TMO) begin
                    drop = 1;
                    busy = 0;
                    idle = 0;
                    rx.delete();
                end
            end
            exp_drop = drop;
            if (drop && exp_cnt != 8'd255) exp_cnt++;
        end
    end

    bit run_cmp = 0;

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("out_valid", out_valid, exp_valid);
            chk("err_drop", err_drop, exp_drop);
            chk("drop_count", drop_count, exp_cnt);
            if (exp_valid) begin
                chk("out_data", out_data, pay[0]);
                chk("out_last", out_last, pay.size() == 1);
                chk("frm_dst", frm_dst, exp_dst);
                chk("frm_src", frm_src, exp_src);
                chk("frm_len", frm_len, exp_len);
            end
        end
    end

    logic [8:0] beats[$];
    int drops  = 0;
    int valids = 0;

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) beats.push_back({out_last, out_data});
        if (reset && err_drop) drops++;
        if (reset && out_valid) valids++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rec_complete = 1'b1;
        din          = b;
        @(negedge clk);
        rec_complete = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] s,
                              input logic [7:0] len, input logic [7:0] p[$]);
        for (int i = 0; i < MB; i++) send_byte(d);
        for (int i = 0; i < MB; i++) send_byte(s);
        send_byte(len);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beats.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("beat_count", beats.size(), n);
    endtask

    task automatic chk_beats(input string name, input logic [8:0] req[$]);
        chk({name, "_n"}, beats.size(), req.size());
        foreach (req[i]) begin
            if (i < beats.size()) chk(name, beats[i], req[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[$];
        logic [7:0] none[$];
        logic [8:0] eb[$];
        int d0;
        int v0;

        reset        = 1'b0;
        rec_complete = 1'b0;
        din          = '0;
        out_ready    = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt", drop_count, 8'd0);
        chk("rst_dst", frm_dst, 96'd0);
        chk("rst_data", out_data, 8'd0);
        chk("rst_drop", err_drop, 1'b0);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        run_cmp = 1;

        // basic frame, consumer always ready
        out_ready = 1'b1;
        d0 = drops;
        p  = '{8'h11, 8'h22, 8'h33};
        send_frame(8'hA1, 8'hB2, 8'd3, p);
        wait_beats(3, 20);
        eb = '{9'h011, 9'h022, 9'h133};
        chk_beats("t1_beat", eb);
        chk("t1_dst", frm_dst, {12{8'hA1}});
        chk("t1_src", frm_src, {12{8'hB2}});
        chk("t1_len", frm_len, 8'd3);
        chk("t1_drops", drops - d0, 0);

        // same frame with ready pattern 1,0,0 repeating
        beats.delete();
        out_ready = 1'b0;
        send_frame(8'hA1, 8'hB2, 8'd3, p);
        for (int k = 0; k < 60 && beats.size() < 3; k++) begin
            @(negedge clk);
            out_ready = (k % 3 == 0);
        end
        chk_beats("t2_beat", eb);
        chk("t2_idle", out_valid, 1'b0);
        out_ready = 1'b1;

        // LEN=0 and LEN=17 both rejected
        d0 = drops;
        v0 = valids;
        send_frame(8'hC3, 8'hD4, 8'd0, none);
        send_frame(8'hC3, 8'hD4, 8'd17, none);
        repeat (2) @(negedge clk);
        chk("t3_drops", drops - d0, 2);
        chk("t3_cnt", drop_count, 8'd2);
        chk("t3_valids", valids - v0, 0);

        // stall mid-SRC until timeout, then a good frame
        d0 = drops;
        for (int i = 0; i < MB; i++) send_byte(8'hE5);
        for (int i = 0; i < 5; i++) send_byte(8'hF6);
        repeat (1030) @(negedge clk);
        chk("t4_drops", drops - d0, 1);
        chk("t4_cnt", drop_count, 8'd3);
        beats.delete();
        p = '{8'h01, 8'h02};
        send_frame(8'h5A, 8'hA5, 8'd2, p);
        wait_beats(2, 20);
        eb = '{9'h001, 9'h102};
        chk_beats("t4_beat", eb);
        chk("t4_dst", frm_dst, {12{8'h5A}});

        // byte during HOLD, then saturate the drop counter
        out_ready = 1'b0;
        beats.delete();
        p = '{8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(8'hAA, 8'hBB, 8'd4, p);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("t5_hold", out_valid, 1'b1);
        d0 = drops;
        send_byte(8'h99);
        @(negedge clk);
        chk("t5_drops", drops - d0, 1);
        chk("t5_cnt", drop_count, 8'd4);
        out_ready = 1'b1;
        wait_beats(4, 20);
        eb = '{9'h005, 9'h006, 9'h007, 9'h108};
        chk_beats("t5_beat", eb);
        for (int i = 0; i < 300; i++) send_frame(8'h00, 8'h00, 8'd0, none);
        repeat (2) @(negedge clk);
        chk("t5_sat", drop_count, 8'd255);
        chk("t5_pulses", drops - d0, 301);

        // reset in the middle of the payload
        beats.delete();
        for (int i = 0; i < MB; i++) send_byte(8'h31);
        for (int i = 0; i < MB; i++) send_byte(8'h42);
        send_byte(8'd5);
        send_byte(8'h71);
        send_byte(8'h72);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_cnt", drop_count, 8'd0);
        chk("t6_dst", frm_dst, 96'd0);
        chk("t6_len", frm_len, 8'd0);
        chk("t6_drop", err_drop, 1'b0);
        d0 = drops;
        @(negedge clk);
        #2 reset = 1'b1;
        p = '{8'hAB, 8'hCD};
        send_frame(8'h13, 8'h24, 8'd2, p);
        wait_beats(2, 20);
        eb = '{9'h0AB, 9'h1CD};
        chk_beats("t6_beat", eb);
        chk("t6_dst2", frm_dst, {12{8'h13}});
        chk("t6_src2", frm_src, {12{8'h24}});
        chk("t6_drops", drops - d0, 0);
        chk("t6_cnt2", drop_count, 8'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
